tri_bus_driver: RTL
===================

TRI_BUS_DRIVER -- requirements
Module: tri_bus_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pad bus width in bits.
REQ-002 SHALL have parameter CHANNELS, default 4, number of requesting sources (2..16).
REQ-003 SHALL have parameter TURN_CYC, default 1, hi-Z turnaround cycles between bus owners (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  CHANNELS  per-channel bus request, level, held until done.
REQ-007 SHALL have port data_in  input  CHANNELS*WIDTH  channel n data at bits [n*WIDTH +: WIDTH].
REQ-008 SHALL have port grant  output  CHANNELS  one-hot owner indication, all-zero when no owner.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port pad_o  output  WIDTH  registered data to the I/O buffers.
REQ-011 SHALL have port pad_t  output  WIDTH  registered per-bit tristate control, 1 = high-Z, 0 = drive.

Function
REQ-012 SHALL implement FSM states IDLE, TURN, DRIVE, RELEASE.
REQ-013 IDLE: pad_t all-ones, grant zero; on any req bit set, latch round-robin winner, go TURN.
REQ-014 TURN: pad_t all-ones, count TURN_CYC cycles, then go DRIVE; if the winner's req drops during TURN, go RELEASE without driving.
REQ-015 DRIVE: grant[winner]=1, pad_t all-zeros, pad_o = data_in of winner registered each cycle (one-cycle latency data_in -> pad_o).
REQ-016 DRIVE -> RELEASE on the first cycle winner's req is sampled low; pad_t all-ones in the next cycle, grant cleared in that same cycle.
REQ-017 RELEASE: pad_t all-ones for TURN_CYC cycles, then IDLE; requests arriving during RELEASE are held and arbitrated in IDLE.
REQ-018 Round-robin: search starts at (last winner + 1) mod CHANNELS; after reset, channel 0 has highest priority.
REQ-019 Simultaneous requests: exactly one winner; the others wait with no loss of request.
REQ-020 pad_t and grant SHALL never indicate drive in the same cycle as a different owner's drive (never two owners, never drive in TURN/RELEASE).
REQ-021 Turnaround counter width SHALL be 4 bits; wraps never, reloaded on each state entry.

Reset
REQ-022 On rst_n low, immediately: state IDLE, pad_t all-ones, pad_o zero, grant zero, busy zero, counter zero, round-robin pointer to channel 0.
REQ-023 Reset mid-DRIVE SHALL release the bus asynchronously (pad_t all-ones) without waiting for a clock edge.
REQ-024 Deassertion of rst_n SHALL leave the block in IDLE; the first grant requires a full TURN.

Configuration
REQ-025 Macro TRI_BUS_PARK_EN: when defined, the last owner's pad_o value stays driven (pad_t all-zeros) in IDLE after RELEASE only if the same channel requests again next, and a new request from that same channel skips TURN (IDLE -> DRIVE directly); a different channel still receives a full TURN.
REQ-026 Without TRI_BUS_PARK_EN, the bus is always high-Z in IDLE and every grant passes through TURN.

Structure
REQ-027 Package tri_bus_pkg SHALL hold the FSM state enum, turnaround counter width constant and the parameter range limits.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (CHANNELS parameter, req in, pointer in, one-hot winner out, combinational).

Verification
REQ-029 Single request: TURN_CYC=1, req=4'b0010, data 8'hA5 -> pad_t zero and grant=4'b0010 at cycle 3 after req, pad_o=8'hA5.
REQ-030 Contention: req=4'b1111 held, each owner drops after 4 DRIVE cycles -> grant order 0,1,2,3,0, each separated by TURN_CYC+TURN_CYC hi-Z cycles.
REQ-031 Turnaround: TURN_CYC=3, owner 0 releases, channel 2 waiting -> exactly 6 cycles of pad_t all-ones between owners.
REQ-032 Abort: req drops during TURN -> no cycle with pad_t zero, return to IDLE after TURN_CYC RELEASE cycles.
REQ-033 Reset: rst_n low mid-DRIVE between edges -> pad_t all-ones, grant zero before next clock edge.
REQ-034 TRI_BUS_PARK_EN defined: channel 1 re-requests after release -> drive with no TURN; channel 2 requests -> full TURN first.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// ---------------------------------------------------------------------------
// tri_bus_pkg
// Shared definitions for the tri-state bus driver slice.
//   state_e         : bus-ownership FSM states (IDLE, TURN, DRIVE, RELEASE)
//   CNT_W           : width of the turnaround counter
//   PTR_W           : width of the round-robin pointer (covers MAX_CHANNELS)
//   MIN_/MAX_*      : legal ranges for CHANNELS and TURN_CYC
//   onehotToIndex() : converts a one-hot channel vector to its index
// ---------------------------------------------------------------------------
package tri_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TURN    = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int CNT_W        = 4;
  localparam int PTR_W        = 4;
  localparam int MIN_CHANNELS = 2;
  localparam int MAX_CHANNELS = 16;
  localparam int MIN_TURN_CYC = 1;
  localparam int MAX_TURN_CYC = 15;

  // Returns the index of the set bit; an all-zero input maps to index 0,
  // which callers only use when a channel has actually been selected.
  function automatic logic [PTR_W-1:0] onehotToIndex(input logic [MAX_CHANNELS-1:0] oneHot);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      if (oneHot[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tri_bus_driver_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The request vector is rotated so the
// pointer channel sits at bit 0, the lowest set bit is isolated, and the
// result is rotated back into channel order.
//   req_i   [CHANNELS] : per-channel requests
//   ptr_i   [PTR_W]    : channel index with highest priority this round
//   grant_o [CHANNELS] : one-hot winner, all-zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter
  import tri_bus_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [PTR_W-1:0]    ptr_i,
  output logic [CHANNELS-1:0] grant_o
);

  logic [2*CHANNELS-1:0] reqDbl;
  logic [2*CHANNELS-1:0] grantDbl;
  logic [CHANNELS-1:0]   reqRot;
  logic [CHANNELS-1:0]   grantRot;

  // Doubling the vector before shifting turns the shift into a rotation,
  // and x & -x keeps only the lowest set bit of the rotated requests.
  always_comb begin
    reqDbl   = {req_i, req_i} >> ptr_i;
    reqRot   = reqDbl[CHANNELS-1:0];
    grantRot = reqRot & (~reqRot + CHANNELS'(1));
    grantDbl = {grantRot, grantRot} << ptr_i;
    grant_o  = grantDbl[2*CHANNELS-1:CHANNELS];
  end

endmodule

// File: rtl/tri_bus_driver.sv
// ---------------------------------------------------------------------------
// tri_bus_driver
// Shares one tri-state pad bus between CHANNELS requesters. A winner is
// chosen round-robin, the bus sits high-Z for TURN_CYC cycles, the winner's
// data is driven while its request stays high, and the bus is released with
// another TURN_CYC high-Z cycles before the next owner can drive.
//   clk      : clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   req      [CHANNELS]       : level requests, held until the owner is done
//   data_in  [CHANNELS*WIDTH] : channel n data at [n*WIDTH +: WIDTH]
//   grant    [CHANNELS]       : one-hot current owner, zero when none
//   busy                      : high whenever the FSM is not in IDLE
//   pad_o    [WIDTH]          : registered pad data
//   pad_t    [WIDTH]          : registered tristate enable, 1 = high-Z
// Optional feature macro TRI_BUS_PARK_EN: the last owner re-requesting the
// bus goes straight to DRIVE with no TURN; any other channel still turns.
// ---------------------------------------------------------------------------
module tri_bus_driver
  import tri_bus_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int TURN_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       grant,
  output logic                      busy,
  output logic [WIDTH-1:0]          pad_o,
  output logic [WIDTH-1:0]          pad_t
);

  if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : gBadChannels
    $error("tri_bus_driver: CHANNELS out of range");
  end
  if (TURN_CYC < MIN_TURN_CYC || TURN_CYC > MAX_TURN_CYC) begin : gBadTurnCyc
    $error("tri_bus_driver: TURN_CYC out of range");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    turnCnt_q, turnCnt_d;
  logic [PTR_W-1:0]    rrPtr_q, rrPtr_d;
  logic [CHANNELS-1:0] winOh_q, winOh_d;
  logic [CHANNELS-1:0] grant_q;
  logic [WIDTH-1:0]    padO_q;
  logic [WIDTH-1:0]    padT_q;

  logic [CHANNELS-1:0] rrWin;
  logic [PTR_W-1:0]    rrWinIdx;
  logic [PTR_W-1:0]    nextPtr;
  logic [WIDTH-1:0]    driveData;
  logic                anyReq;
  logic                winReq;
  logic                turnDone;
  logic                skipTurn;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) uArbiter (
    .req_i   (req),
    .ptr_i   (rrPtr_q),
    .grant_o (rrWin)
  );

  assign anyReq   = |req;
  assign winReq   = |(req & winOh_q);
  assign turnDone = (turnCnt_q == CNT_W'(TURN_CYC - 1));
  assign rrWinIdx = onehotToIndex(MAX_CHANNELS'(rrWin));
  assign nextPtr  = (rrWinIdx == PTR_W'(CHANNELS - 1)) ? '0 : rrWinIdx + PTR_W'(1);

`ifdef TRI_BUS_PARK_EN
  logic [CHANNELS-1:0] parkOh_q;
  logic                parkValid_q;

  // Remember the most recent channel that actually drove the pads, so an
  // immediate re-request from it can skip the turnaround.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parkOh_q    <= '0;
      parkValid_q <= 1'b0;
    end else if (state_d == DRIVE) begin
      parkOh_q    <= winOh_d;
      parkValid_q <= 1'b1;
    end
  end

  assign skipTurn = parkValid_q && (rrWin == parkOh_q);
`else
  assign skipTurn = 1'b0;
`endif

  // Next-state logic. When RELEASE finishes with requests already waiting,
  // the IDLE arbitration is folded into that cycle so the gap between two
  // owners is exactly TURN_CYC release plus TURN_CYC turnaround cycles.
  // The counter is cleared on every state entry and counts up to
  // TURN_CYC-1, so it never wraps.
  always_comb begin
    state_d   = state_q;
    turnCnt_d = turnCnt_q;
    rrPtr_d   = rrPtr_q;
    winOh_d   = winOh_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          winOh_d   = rrWin;
          rrPtr_d   = nextPtr;
          turnCnt_d = '0;
          state_d   = skipTurn ? DRIVE : TURN;
        end
      end
      TURN: begin
        if (!winReq) begin
          turnCnt_d = '0;
          state_d   = RELEASE;
        end else if (turnDone) begin
          turnCnt_d = '0;
          state_d   = DRIVE;
        end else begin
          turnCnt_d = turnCnt_q + CNT_W'(1);
        end
      end
      DRIVE: begin
        if (!winReq) begin
          turnCnt_d = '0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (!turnDone) begin
          turnCnt_d = turnCnt_q + CNT_W'(1);
        end else if (anyReq) begin
          winOh_d   = rrWin;
          rrPtr_d   = nextPtr;
          turnCnt_d = '0;
          state_d   = skipTurn ? DRIVE : TURN;
        end else begin
          turnCnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        turnCnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Data of whichever channel will own the bus in the coming cycle.
  always_comb begin
    driveData = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (winOh_d[n]) driveData = data_in[n*WIDTH +: WIDTH];
    end
  end

  // State and pad registers. The pad controls follow the next state, so the
  // bus drives exactly in DRIVE cycles and goes high-Z together with the
  // grant clearing. Reset forces the pads high-Z without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      turnCnt_q <= '0;
      rrPtr_q   <= '0;
      winOh_q   <= '0;
      grant_q   <= '0;
      padO_q    <= '0;
      padT_q    <= '1;
    end else begin
      state_q   <= state_d;
      turnCnt_q <= turnCnt_d;
      rrPtr_q   <= rrPtr_d;
      winOh_q   <= winOh_d;
      grant_q   <= (state_d == DRIVE) ? winOh_d : '0;
      padT_q    <= (state_d == DRIVE) ? '0 : '1;
      if (state_d == DRIVE) padO_q <= driveData;
    end
  end

  assign grant = grant_q;
  assign pad_o = padO_q;
  assign pad_t = padT_q;
  assign busy  = (state_q != IDLE);

endmodule
